// File: rtl/seq_ram_arbiter.sv
// -----------------------------------------------------------------------------
// seq_ram_arbiter
//
// Owns the single-port sequence RAM and shares it between the sequence
// generator (write requester) and the game controller (read requester).
// Accesses are serialised, and the RAM's fixed read latency is hidden behind a
// req/ack handshake, so requesters never count fetch/wait/catch cycles.
//
// Optional feature (compile-time macro ARB_RR_EN):
//   defined   : round-robin between simultaneous requests; a one-bit pointer
//               remembers the last-served requester and the other one wins.
//               After reset the pointer says "read served last", so the write
//               wins the first contention.
//   undefined : fixed priority, write always wins; no pointer is built.
//
// Parameters:
//   ADDR_W  address width of the sequence RAM
//   DATA_W  digit width
//   DEPTH   number of valid RAM locations (0..DEPTH-1)
//   RD_LAT  cycles from RAMAddr change to RAMOutput valid (1..7)
//
// Ports:
//   Clk        system clock, rising edge
//   Rst        asynchronous active-low reset
//   WrReq      write request, held until WrAck
//   WrAddr     write address, stable while WrReq high
//   WrData     write digit, stable while WrReq high
//   WrAck      one-cycle pulse: write completed
//   RdReq      read request, held until RdAck
//   RdAddr     read address, stable while RdReq high
//   RdAck      one-cycle pulse: RdData valid
//   RdData     captured digit, holds until the next read completes
//   RAMAddr    RAM address (holds its last value while idle)
//   RAMDataIn  RAM write data
//   RAMWrite   RAM write strobe, one cycle wide
//   RAMOutput  RAM read data
//   Busy       high whenever the arbiter is not idle
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module seq_ram_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              WrReq,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  output logic              WrAck,
  input  logic              RdReq,
  input  logic [ADDR_W-1:0] RdAddr,
  output logic              RdAck,
  output logic [DATA_W-1:0] RdData,
  output logic [ADDR_W-1:0] RAMAddr,
  output logic [DATA_W-1:0] RAMDataIn,
  output logic              RAMWrite,
  input  logic [DATA_W-1:0] RAMOutput,
  output logic              Busy
);

  // One extra bit so that DEPTH == 2**ADDR_W is representable and the
  // unsigned range compare never truncates.
  localparam logic [ADDR_W:0] DepthLim  = (ADDR_W+1)'(DEPTH);
  localparam logic [2:0]      RdLatInit = 3'(RD_LAT);

  typedef enum logic [1:0] {
    Idle    = 2'd0,
    WrIssue = 2'd1,
    RdWait  = 2'd2,
    RdCatch = 2'd3
  } stateT;

  stateT             state;
  stateT             stateNext;
  logic [2:0]        latCnt;
  logic [2:0]        latCntNext;

  logic              wrEligible;
  logic              rdEligible;
  logic              grantWr;
  logic              grantRd;

  logic [ADDR_W-1:0] ramAddrNext;
  logic [DATA_W-1:0] ramDataInNext;
  logic              ramWriteNext;
  logic              wrAckNext;
  logic              rdAckNext;
  logic [DATA_W-1:0] rdDataNext;
  logic              busyNext;

  function automatic logic inRange(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < DepthLim);
  endfunction

  // A requester whose ack is high right now is still holding its old request;
  // masking it here prevents the same access from being granted twice.
  assign wrEligible = WrReq & ~WrAck;
  assign rdEligible = RdReq & ~RdAck;

`ifdef ARB_RR_EN
  // 1 = read was served last, so the write wins the next tie.
  logic lastRd;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      lastRd <= 1'b1;
    end else if (grantWr) begin
      lastRd <= 1'b0;
    end else if (grantRd) begin
      lastRd <= 1'b1;
    end
  end
`endif

  // Grant selection, only meaningful in Idle.
  always_comb begin
    grantWr = 1'b0;
    grantRd = 1'b0;
    if (state == Idle) begin
      if (wrEligible && rdEligible) begin
`ifdef ARB_RR_EN
        grantWr = lastRd;
        grantRd = ~lastRd;
`else
        // Generator fills the sequence before play starts, so writes win.
        grantWr = 1'b1;
`endif
      end else begin
        grantWr = wrEligible;
        grantRd = rdEligible;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state  <= Idle;
      latCnt <= 3'd0;
    end else begin
      state  <= stateNext;
      latCnt <= latCntNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext  = state;
    latCntNext = latCnt;
    case (state)
      Idle: begin
        if (grantWr) begin
          stateNext = WrIssue;
        end else if (grantRd) begin
          stateNext  = RdWait;
          latCntNext = RdLatInit;
        end
      end
      WrIssue: begin
        stateNext = Idle;
      end
      RdWait: begin
        // Counter starts at RD_LAT, so RdWait lasts exactly RD_LAT cycles.
        latCntNext = latCnt - 3'd1;
        if (latCnt == 3'd1) begin
          stateNext = RdCatch;
        end
      end
      RdCatch: begin
        stateNext = Idle;
      end
      default: begin
        stateNext  = Idle;
        latCntNext = 3'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values of the registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ramAddrNext   = RAMAddr;
    ramDataInNext = RAMDataIn;
    ramWriteNext  = 1'b0;
    wrAckNext     = 1'b0;
    rdAckNext     = 1'b0;
    rdDataNext    = RdData;
    busyNext      = (stateNext != Idle);
    case (state)
      Idle: begin
        if (grantWr) begin
          ramAddrNext   = WrAddr;
          ramDataInNext = WrData;
          // Out-of-range writes still complete and ack, but never strobe.
          ramWriteNext  = inRange(WrAddr);
        end else if (grantRd) begin
          ramAddrNext = RdAddr;
        end
      end
      WrIssue: begin
        wrAckNext = 1'b1;
      end
      RdCatch: begin
        // RAMAddr still holds the granted read address, so the range check
        // does not depend on the requester keeping RdAddr stable.
        rdDataNext = inRange(RAMAddr) ? RAMOutput : '0;
        rdAckNext  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      RAMAddr   <= '0;
      RAMDataIn <= '0;
      RAMWrite  <= 1'b0;
      WrAck     <= 1'b0;
      RdAck     <= 1'b0;
      RdData    <= '0;
      Busy      <= 1'b0;
    end else begin
      RAMAddr   <= ramAddrNext;
      RAMDataIn <= ramDataInNext;
      RAMWrite  <= ramWriteNext;
      WrAck     <= wrAckNext;
      RdAck     <= rdAckNext;
      RdData    <= rdDataNext;
      Busy      <= busyNext;
    end
  end

endmodule

// File: tb/tb_seq_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_seq_ram_arbiter
//
// Bench for seq_ram_arbiter (DEPTH=20, RD_LAT=2). A transaction-level model
// predicts every registered output cycle by cycle from access durations
// (write = 2 cycles, read = RD_LAT+2 cycles), and directed sequences add
// hand-computed literal expectations. A small RAM with a RD_LAT-cycle read
// pipeline sits behind the arbiter. Honours ARB_RR_EN the same way the design
// does.
// -----------------------------------------------------------------------------
module tb_seq_ram_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 20;
  localparam int RD_LAT = 2;

  logic              Clk = 1'b0;
  logic              Rst;
  logic              WrReq;
  logic [ADDR_W-1:0] WrAddr;
  logic [DATA_W-1:0] WrData;
  logic              WrAck;
  logic              RdReq;
  logic [ADDR_W-1:0] RdAddr;
  logic              RdAck;
  logic [DATA_W-1:0] RdData;
  logic [ADDR_W-1:0] RAMAddr;
  logic [DATA_W-1:0] RAMDataIn;
  logic              RAMWrite;
  logic [DATA_W-1:0] RAMOutput;
  logic              Busy;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int wrPulses = 0;
  bit cmpOn    = 1'b0;

  seq_ram_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .RD_LAT(RD_LAT)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .WrReq    (WrReq),
    .WrAddr   (WrAddr),
    .WrData   (WrData),
    .WrAck    (WrAck),
    .RdReq    (RdReq),
    .RdAddr   (RdAddr),
    .RdAck    (RdAck),
    .RdData   (RdData),
    .RAMAddr  (RAMAddr),
    .RAMDataIn(RAMDataIn),
    .RAMWrite (RAMWrite),
    .RAMOutput(RAMOutput),
    .Busy     (Busy)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] initVal(input int i);
    return 4'((i * 7 + 3) % 16);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // RAM behind the arbiter: RD_LAT-stage registered read pipeline
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] ramArr [32];
  logic [DATA_W-1:0] ramStage0;
  logic [DATA_W-1:0] ramStage1;
  bit                ramLoaded = 1'b0;

  always @(posedge Clk) begin
    if (!ramLoaded) begin
      for (int i = 0; i < 32; i++) ramArr[i] <= initVal(i);
      ramLoaded <= 1'b1;
    end else if (RAMWrite) begin
      ramArr[RAMAddr] <= RAMDataIn;
    end
    ramStage0 <= ramArr[RAMAddr];
    ramStage1 <= ramStage0;
  end
  assign RAMOutput = ramStage1;

  // ---------------------------------------------------------------------------
  // Transaction-level model: an access occupies a fixed number of cycles; the
  // ack appears on the edge that ends it, and a new grant is possible on the
  // edge after that.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] shadow [32];
  int                busyLeft;
  logic              mCurWr;
  logic [ADDR_W-1:0] mCurAddr;
  logic              mWrCan;
  logic              mRdCan;
  logic              mPickWr;
  logic [ADDR_W-1:0] eRamAddr;
  logic [DATA_W-1:0] eRamDataIn;
  logic              eRamWrite;
  logic              eWrAck;
  logic              eRdAck;
  logic [DATA_W-1:0] eRdData;
  logic              eBusy;
`ifdef ARB_RR_EN
  logic              mLastRd;
`endif

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = initVal(i);
  end

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      eRamAddr   = '0;
      eRamDataIn = '0;
      eRamWrite  = 1'b0;
      eWrAck     = 1'b0;
      eRdAck     = 1'b0;
      eRdData    = '0;
      eBusy      = 1'b0;
      busyLeft   = 0;
      mCurWr     = 1'b0;
      mCurAddr   = '0;
`ifdef ARB_RR_EN
      mLastRd    = 1'b1;
`endif
    end else begin
      mWrCan    = WrReq && !eWrAck;
      mRdCan    = RdReq && !eRdAck;
      eRamWrite = 1'b0;
      eWrAck    = 1'b0;
      eRdAck    = 1'b0;
      if (busyLeft > 0) begin
        busyLeft = busyLeft - 1;
        if (busyLeft == 0) begin
          if (mCurWr) begin
            eWrAck = 1'b1;
          end else begin
            eRdAck  = 1'b1;
            eRdData = (int'(mCurAddr) < DEPTH) ? shadow[mCurAddr] : '0;
          end
        end
      end else if (mWrCan || mRdCan) begin
`ifdef ARB_RR_EN
        mPickWr = mWrCan && (!mRdCan || mLastRd);
        mLastRd = !mPickWr;
`else
        mPickWr = mWrCan;
`endif
        mCurWr = mPickWr;
        if (mPickWr) begin
          busyLeft   = 1;
          eRamAddr   = WrAddr;
          eRamDataIn = WrData;
          if (int'(WrAddr) < DEPTH) begin
            eRamWrite      = 1'b1;
            shadow[WrAddr] = WrData;
          end
        end else begin
          busyLeft = RD_LAT + 1;
          eRamAddr = RdAddr;
          mCurAddr = RdAddr;
        end
      end
      eBusy = (busyLeft > 0);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge Clk) begin
    if (cmpOn) begin
      chk("cyc_RAMAddr",   32'(RAMAddr),   32'(eRamAddr));
      chk("cyc_RAMDataIn", 32'(RAMDataIn), 32'(eRamDataIn));
      chk("cyc_RAMWrite",  32'(RAMWrite),  32'(eRamWrite));
      chk("cyc_WrAck",     32'(WrAck),     32'(eWrAck));
      chk("cyc_RdAck",     32'(RdAck),     32'(eRdAck));
      chk("cyc_RdData",    32'(RdData),    32'(eRdData));
      chk("cyc_Busy",      32'(Busy),      32'(eBusy));
      if (RAMWrite) wrPulses++;
    end
  end

  // ---------------------------------------------------------------------------
  // Requester tasks
  // ---------------------------------------------------------------------------
  task automatic writeTxn(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input int hold, output int ackCyc);
    int n;
    WrAddr = a;
    WrData = d;
    WrReq  = 1'b1;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!WrAck && n < 40);
    chk("wr_ack_seen", 32'(WrAck), 32'd1);
    ackCyc = cyc;
    repeat (hold) @(negedge Clk);
    WrReq = 1'b0;
    $display("WR addr=%0d data=%0d ack_cycle=%0d", a, d, ackCyc);
  endtask

  task automatic readTxn(input logic [ADDR_W-1:0] a, input int hold,
                         output logic [DATA_W-1:0] d, output int ackCyc);
    int n;
    RdAddr = a;
    RdReq  = 1'b1;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!RdAck && n < 40);
    chk("rd_ack_seen", 32'(RdAck), 32'd1);
    d      = RdData;
    ackCyc = cyc;
    repeat (hold) @(negedge Clk);
    RdReq = 1'b0;
    $display("RD addr=%0d data=%0d ack_cycle=%0d", a, d, ackCyc);
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, "_RAMAddr"},   32'(RAMAddr),   32'd0);
    chk({tag, "_RAMDataIn"}, 32'(RAMDataIn), 32'd0);
    chk({tag, "_RAMWrite"},  32'(RAMWrite),  32'd0);
    chk({tag, "_WrAck"},     32'(WrAck),     32'd0);
    chk({tag, "_RdAck"},     32'(RdAck),     32'd0);
    chk({tag, "_RdData"},    32'(RdData),    32'd0);
    chk({tag, "_Busy"},      32'(Busy),      32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  int                wcA, rcA, wcB, rcB, c1, c2, pulsesBefore;
  logic [DATA_W-1:0] rdA, rdB, rdv;
  bit                sawAck;
  logic [ADDR_W-1:0] tabAddr [4];
  logic [DATA_W-1:0] tabData [4];

  initial begin
    Rst    = 1'b0;
    WrReq  = 1'b0;
    WrAddr = '0;
    WrData = '0;
    RdReq  = 1'b0;
    RdAddr = '0;
    repeat (3) @(negedge Clk);
    chkAllZero("reset");
    cmpOn = 1'b1;
    Rst   = 1'b1;
    repeat (2) @(negedge Clk);

    // Single write: strobe after edge 1, ack after edge 2.
    WrAddr = 5'd3; WrData = 4'd7; WrReq = 1'b1;
    @(negedge Clk);
    chk("w1_RAMWrite",  32'(RAMWrite),  32'd1);
    chk("w1_RAMAddr",   32'(RAMAddr),   32'd3);
    chk("w1_RAMDataIn", 32'(RAMDataIn), 32'd7);
    chk("w1_Busy",      32'(Busy),      32'd1);
    @(negedge Clk);
    chk("w1_WrAck",     32'(WrAck),     32'd1);
    chk("w1_strobe_end", 32'(RAMWrite), 32'd0);
    chk("w1_Busy_low",  32'(Busy),      32'd0);
    WrReq = 1'b0;
    @(negedge Clk);
    chk("w1_ack_pulse", 32'(WrAck), 32'd0);
    $display("WR addr=3 data=7 directed");

    // Single read: address after edge 1, ack and data after edge 4.
    RdAddr = 5'd3; RdReq = 1'b1;
    @(negedge Clk);
    chk("r1_RAMAddr", 32'(RAMAddr), 32'd3);
    @(negedge Clk);
    chk("r1_early2",  32'(RdAck), 32'd0);
    @(negedge Clk);
    chk("r1_early3",  32'(RdAck), 32'd0);
    @(negedge Clk);
    chk("r1_RdAck",   32'(RdAck),  32'd1);
    chk("r1_RdData",  32'(RdData), 32'd7);
    RdReq = 1'b0;
    @(negedge Clk);
    chk("r1_ack_pulse", 32'(RdAck),  32'd0);
    chk("r1_hold",      32'(RdData), 32'd7);
    $display("RD addr=3 data=7 directed");

    // Reset in the middle of a read: outputs clear at once, no late ack.
    RdAddr = 5'd5; RdReq = 1'b1;
    repeat (2) @(negedge Clk);
    #2 Rst = 1'b0;
    #1 chkAllZero("async_rst");
    RdReq = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    sawAck = 1'b0;
    repeat (6) begin
      @(negedge Clk);
      sawAck = sawAck | RdAck;
    end
    chk("rst_no_ack", 32'(sawAck), 32'd0);
    readTxn(5'd5, 0, rdv, c1);
    chk("rst_fresh_read", 32'(rdv), 32'd6);
    @(negedge Clk);

    // Contention A: write wins in both builds; read returns the new digit.
    fork
      writeTxn(5'd5, 4'd2, 0, wcA);
      readTxn(5'd5, 0, rdA, rcA);
    join
    chk("contA_wr_first", 32'(wcA < rcA), 32'd1);
    chk("contA_rd_data",  32'(rdA), 32'd2);
    @(negedge Clk);

    // Lone write, then contention B: round-robin now favours the read.
    writeTxn(5'd6, 4'd1, 0, c1);
    @(negedge Clk);
    fork
      writeTxn(5'd6, 4'd9, 0, wcB);
      readTxn(5'd3, 0, rdB, rcB);
    join
`ifdef ARB_RR_EN
    chk("contB_rd_first", 32'(rcB < wcB), 32'd1);
`else
    chk("contB_wr_first", 32'(wcB < rcB), 32'd1);
`endif
    chk("contB_rd_data", 32'(rdB), 32'd7);
    @(negedge Clk);

    // Write request held through its ack cycle: masked, read granted instead.
    pulsesBefore = wrPulses;
    fork
      writeTxn(5'd8, 4'd4, 1, c1);
      begin
        @(negedge Clk);
        readTxn(5'd8, 0, rdv, c2);
      end
    join
    chk("held_one_strobe", 32'(wrPulses - pulsesBefore), 32'd1);
    chk("held_rd_data",    32'(rdv), 32'd4);
    chk("held_no_bubble",  32'(c2 - c1), 32'(RD_LAT + 2));
    @(negedge Clk);

    // Out-of-range accesses (DEPTH=20).
    pulsesBefore = wrPulses;
    writeTxn(5'd25, 4'd9, 0, c1);
    writeTxn(5'd20, 4'd5, 0, c1);
    chk("oor_no_strobe", 32'(wrPulses - pulsesBefore), 32'd0);
    readTxn(5'd25, 0, rdv, c1);
    chk("oor_rd25_zero", 32'(rdv), 32'd0);
    readTxn(5'd20, 0, rdv, c1);
    chk("oor_rd20_zero", 32'(rdv), 32'd0);
    readTxn(5'd19, 0, rdv, c1);
    chk("edge_rd19", 32'(rdv), 32'd8);

    // Small write/readback table.
    tabAddr[0] = 5'd0;  tabData[0] = 4'd15;
    tabAddr[1] = 5'd11; tabData[1] = 4'd1;
    tabAddr[2] = 5'd19; tabData[2] = 4'd14;
    tabAddr[3] = 5'd12; tabData[3] = 4'd6;
    for (int i = 0; i < 4; i++) writeTxn(tabAddr[i], tabData[i], 0, c1);
    for (int i = 0; i < 4; i++) begin
      readTxn(tabAddr[i], 0, rdv, c1);
      chk("tab_readback", 32'(rdv), 32'(tabData[i]));
    end
    readTxn(5'd6, 0, rdv, c1);
    chk("contB_wr_landed", 32'(rdv), 32'd9);

    repeat (3) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
